// File: rtl/hazard_unit.sv
// hazard_unit
//   Pipeline hazard controller. Produces the hold (stall_*) and clear (flush_*)
//   controls for the PC, F/D, D/E and E/M pipeline registers, plus the
//   execute-stage forwarding selects. It detects load-use hazards, taken
//   control transfers in execute and multi-cycle mul/div occupancy of execute.
//   It also keeps saturating performance counters for stall cycles and flush
//   events.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   rs1_d, rs2_d             decode-stage source registers
//   rs1_e, rs2_e, rd_e       execute-stage register numbers
//   res_src_e                execute result source (2'b01 = load)
//   pc_src_e                 taken branch/jump in execute
//   muldiv_e                 mul/div instruction in execute
//   rd_m, rd_w               destinations in memory / writeback
//   reg_write_m, reg_write_w writeback enables in memory / writeback
//   stall_f/d/e              hold PC, F/D, D/E
//   flush_d/e/m              clear F/D, D/E, E/M
//   forward_a_e, forward_b_e 00 regfile, 10 M result, 01 W result
//   md_last                  final mul/div execute cycle, result valid
//   perf_stall_cycles        cycles with stall_f asserted (saturating)
//   perf_flush_events        cycles with flush_d or flush_e (saturating)
//
// FSM states
//   state   | meaning
//   RUN     | execute free; a mul/div seen here starts occupancy
//   MD_BUSY | mul/div holding execute; cnt counts remaining stall cycles
module hazard_unit #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            rs1_d,
    input  logic [4:0]            rs2_d,
    input  logic [4:0]            rs1_e,
    input  logic [4:0]            rs2_e,
    input  logic [4:0]            rd_e,
    input  logic [1:0]            res_src_e,
    input  logic                  pc_src_e,
    input  logic                  muldiv_e,
    input  logic [4:0]            rd_m,
    input  logic [4:0]            rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_m,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  md_last,
    output logic [PERF_WIDTH-1:0] perf_stall_cycles,
    output logic [PERF_WIDTH-1:0] perf_flush_events
);

    // The first mul/div cycle is spent in RUN and the md_last cycle has cnt=0,
    // so the counter is loaded with the remaining middle cycles only.
    localparam logic [7:0] CNT_LOAD = 8'(MULDIV_LAT - 2);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic [PERF_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic md_stall;
    logic md_done;
    logic lw_stall;
    logic stall_raw;
    logic flush_d_raw;
    logic flush_e_raw;

    // M-stage result has priority over W-stage since it is the younger write.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdm,
        input logic       wem,
        input logic [4:0] rdw,
        input logic       wew
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wem && (rdm != 5'd0) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (wew && (rdw != 5'd0) && (rdw == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Mul/div occupancy FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (muldiv_e) begin
                    md_stall = 1'b1;
                    state_d  = MD_BUSY;
                    cnt_d    = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q != 8'd0) begin
                    md_stall = 1'b1;
                    cnt_d    = cnt_q - 8'd1;
                end else begin
                    md_done = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Hazard detection
    always_comb begin
        lw_stall = (res_src_e == 2'b01) && (rd_e != 5'd0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));
        stall_raw = lw_stall | md_stall;
        // A held D/E register must never be cleared, so mul/div dominates.
        flush_d_raw = pc_src_e & ~md_stall;
        flush_e_raw = (lw_stall | pc_src_e) & ~md_stall;
    end

    // Outputs are forced inactive while reset is held.
    always_comb begin
        stall_f     = stall_raw & ~rst;
        stall_d     = stall_raw & ~rst;
        stall_e     = md_stall & ~rst;
        flush_m     = md_stall & ~rst;
        flush_d     = flush_d_raw & ~rst;
        flush_e     = flush_e_raw & ~rst;
        md_last     = md_done & ~rst;
        forward_a_e = rst ? 2'b00 : fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
        forward_b_e = rst ? 2'b00 : fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if ((flush_d || flush_e) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_events = flush_cnt_q;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline control block that drives the hold (`en`) and clear (`clr`) inputs of the F/D, D/E and E/M pipeline registers, and the execute-stage forwarding selects.
- Detects load-use hazards, taken branches and jumps, and multi-cycle mul/div occupancy of execute.
- Counts stall cycles and flush events for performance monitoring.
- Sits beside the datapath. Its stall/flush outputs feed the pipeline registers, which hold when `en`=1 and clear when `clr`=1, with clear taking priority.

## Interface
Parameters:
- `MULDIV_LAT`, 4: total cycles a mul/div instruction occupies execute; legal range 2..255.
- `PERF_WIDTH`, 32: width of the performance counters.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `rs1_d`, `rs2_d`  in  5  decode-stage source registers
- `rs1_e`, `rs2_e`, `rd_e`  in  5  execute-stage register numbers
- `res_src_e`  in  2  execute result source; `2'b01` = load
- `pc_src_e`  in  1  taken branch or jump in execute
- `muldiv_e`  in  1  mul/div instruction in execute
- `rd_m`, `rd_w`  in  5  destinations in memory and writeback
- `reg_write_m`, `reg_write_w`  in  1  writeback enables
- `stall_f`, `stall_d`, `stall_e`  out  1  hold the PC, F/D and D/E registers
- `flush_d`, `flush_e`, `flush_m`  out  1  clear the F/D, D/E and E/M registers
- `forward_a_e`, `forward_b_e`  out  2  `00` register file, `10` M-stage result, `01` W-stage result
- `md_last`  out  1  final mul/div execute cycle; result valid
- `perf_stall_cycles`, `perf_flush_events`  out  `PERF_WIDTH`  counters

## Operation
- FSM states: RUN and MD_BUSY. An 8-bit down-counter `cnt` belongs to the FSM.
  - RUN with `muldiv_e`=1: go to MD_BUSY and load `cnt` with `MULDIV_LAT`-2.
  - MD_BUSY with `cnt`≠0: decrement `cnt`.
  - MD_BUSY with `cnt`=0: return to RUN.
- `md_stall` = (RUN & `muldiv_e`) | (MD_BUSY & `cnt`≠0).
- `md_last` = MD_BUSY & `cnt`=0.
- `lw_stall` = (`res_src_e`==01) & (`rd_e`≠0) & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
- Stall outputs:
  - `stall_f` = `stall_d` = `lw_stall` | `md_stall`.
  - `stall_e` = `md_stall`.
  - `flush_m` = `md_stall`, which inserts a bubble into M while execute is held.
- Flush outputs:
  - `flush_d` = `pc_src_e` & !`md_stall`.
  - `flush_e` = (`lw_stall` | `pc_src_e`) & !`md_stall`.
  - A mul/div stall always dominates, so a held D/E register is never cleared.
- Forwarding for `forward_a_e` (`forward_b_e` is identical, using `rs2_e`):
  - `10` if `reg_write_m` & `rd_m`≠0 & `rd_m`==`rs1_e`.
  - Else `01` if `reg_write_w` & `rd_w`≠0 & `rd_w`==`rs1_e`.
  - Else `00`. M has priority over W.
- Performance counters:
  - `perf_stall_cycles` increments on every cycle with `stall_f`=1.
  - `perf_flush_events` increments on every cycle with `flush_d` | `flush_e` (one count per cycle).
  - Both counters saturate at all-ones; no wrap.
- `pc_src_e` and `muldiv_e` are never both 1 (a mul/div instruction is not a control transfer). If they are, the mul/div stall wins and the branch flush is suppressed until release.

## Timing
- All stall, flush, forward and `md_last` outputs are combinational from inputs and state. They take effect at the next `clk` edge in the pipeline registers.
- FSM, `cnt` and counters update on the rising `clk` edge.
- Mul/div occupancy, counted from the cycle `muldiv_e` is first seen in RUN:
  - Stalled for `MULDIV_LAT`-1 cycles.
  - Unstalled with `md_last`=1 on cycle `MULDIV_LAT`.
  - Exactly `MULDIV_LAT` cycles in E.
- Back-to-back mul/div: the second instruction enters E after the `md_last` cycle and sees RUN, so it restarts cleanly.
- Load-use costs exactly 1 stall cycle plus 1 bubble. On the next cycle the load is in M and `lw_stall` deasserts.
- Reset (asynchronous, any time, including mid-MD_BUSY):
  - State goes to RUN, `cnt` to 0, both counters to 0.
  - While `rst`=1, every stall, flush and `md_last` output is forced to 0, and forwards to `00`.
  - An aborted mul/div does not resume after reset.

## Test plan
- Load-use: load `x5` in E, `rs1_d`=5 → `stall_f`=`stall_d`=`flush_e`=1 for one cycle. Next cycle all are 0 and `perf_stall_cycles`=1.
- Load with `rd_e`=0 and `rs1_d`=0 → no stall.
- Taken branch: `pc_src_e`=1 → `flush_d`=`flush_e`=1, no stall, `perf_flush_events` +1.
- Mul/div with `MULDIV_LAT`=4: `muldiv_e` held → stalls 1,1,1,0, `md_last` on the 4th cycle. A second back-to-back mul/div gives a fresh 4-cycle pattern.
- Combined hazard: load-use coincident with an MD_BUSY cycle → `flush_e`=0 and `stall_e`=1.
- Forwarding priority: `rd_m`=`rd_w`=`rs1_e`=7, both writes enabled → `forward_a_e`=`10`. With `reg_write_m`=0 → `01`. With `rd`=0 → `00`.
- Reset mid-busy: assert `rst` in the second MD_BUSY cycle → outputs immediately 0 and counters 0. After release with `muldiv_e`=1, a full `MULDIV_LAT` sequence restarts.
